// File: rtl/video_timing_gen.sv
// video_timing_gen: parametrised raster timing generator with DE/sync/coords and a leading frame-buffer address.
// Define VTG_ADDR_EN to build the frame-buffer address path; otherwise oAddr/oAddrVld are tied to 0.
module video_timing_gen #(
    parameter int H_VA   = 640,
    parameter int H_FP   = 16,
    parameter int H_SP   = 96,
    parameter int H_BP   = 48,
    parameter int V_VA   = 480,
    parameter int V_FP   = 10,
    parameter int V_SP   = 2,
    parameter int V_BP   = 33,
    parameter int HS_POL = 0,
    parameter int VS_POL = 0,
    parameter int LEAD   = 0,
    localparam int H_TOT = H_VA + H_FP + H_SP + H_BP,
    localparam int V_TOT = V_VA + V_FP + V_SP + V_BP,
    localparam int HW    = $clog2(H_TOT),
    localparam int VW    = $clog2(V_TOT),
    localparam int AW    = $clog2(H_VA * V_VA)
) (
    input  logic          iClk,
    input  logic          iRst,
    input  logic          iPixEn,
    output logic          oDE,
    output logic          oHS,
    output logic          oVS,
    output logic [HW-1:0] oX,
    output logic [VW-1:0] oY,
    output logic          oFrameStart,
    output logic [AW-1:0] oAddr,
    output logic          oAddrVld
);
    localparam logic [HW-1:0] H_LAST = HW'(H_TOT - 1);
    localparam logic [HW-1:0] H_ACT  = HW'(H_VA);
    localparam logic [HW-1:0] H_SS   = HW'(H_VA + H_FP);
    localparam logic [HW-1:0] H_SE   = HW'(H_VA + H_FP + H_SP);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOT - 1);
    localparam logic [VW-1:0] V_ACT  = VW'(V_VA);
    localparam logic [VW-1:0] V_SS   = VW'(V_VA + V_FP);
    localparam logic [VW-1:0] V_SE   = VW'(V_VA + V_FP + V_SP);
    localparam logic HP = (HS_POL != 0);
    localparam logic VP = (VS_POL != 0);
    localparam int SW = 4 + HW + VW;

    logic [HW-1:0] h;
    logic [VW-1:0] v;
    logic hEnd, vEnd, active, hsync, vsync, fs;

    assign hEnd   = h == H_LAST;
    assign vEnd   = v == V_LAST;
    assign active = h < H_ACT && v < V_ACT;
    assign hsync  = h >= H_SS && h < H_SE;
    assign vsync  = v >= V_SS && v < V_SE;
    assign fs     = h == '0 && v == '0;

    always_ff @(posedge iClk) begin
        if (iRst) begin
            h <= '0;
            v <= '0;
        end else if (iPixEn) begin
            h <= hEnd ? '0 : h + 1'b1;
            if (hEnd) v <= vEnd ? '0 : v + 1'b1;
        end
    end

    // Raw (pre-polarity) decode travels through the lead delay; all-zero is the inactive stage value.
    logic [SW-1:0] dec, stg;
    assign dec = {active, hsync, vsync, fs, h, v};

    generate
        if (LEAD == 0) begin : gNoLead
            assign stg = dec;
        end else begin : gLead
            logic [SW-1:0] pipe [LEAD];
            always_ff @(posedge iClk) begin
                if (iRst) begin
                    for (int i = 0; i < LEAD; i++) pipe[i] <= '0;
                end else if (iPixEn) begin
                    pipe[0] <= dec;
                    for (int i = 1; i < LEAD; i++) pipe[i] <= pipe[i-1];
                end
            end
            assign stg = pipe[LEAD-1];
        end
    endgenerate

    logic sAct, sHs, sVs, sFs;
    logic [HW-1:0] sX;
    logic [VW-1:0] sY;
    assign {sAct, sHs, sVs, sFs, sX, sY} = stg;

    always_ff @(posedge iClk) begin
        if (iRst) begin
            oDE         <= 1'b0;
            oHS         <= ~HP;
            oVS         <= ~VP;
            oFrameStart <= 1'b0;
            oX          <= '0;
            oY          <= '0;
        end else if (iPixEn) begin
            oDE         <= sAct;
            oHS         <= sHs ? HP : ~HP;
            oVS         <= sVs ? VP : ~VP;
            oFrameStart <= sFs;
            oX          <= sX;
            oY          <= sY;
        end
    end

`ifdef VTG_ADDR_EN
    logic [AW-1:0] addrNext;

    always_ff @(posedge iClk) begin
        if (iRst) begin
            addrNext <= '0;
            oAddr    <= '0;
            oAddrVld <= 1'b0;
        end else if (iPixEn) begin
            oAddrVld <= active;
            if (active) begin
                oAddr    <= addrNext;
                addrNext <= addrNext + 1'b1;
            end
            if (hEnd && vEnd) addrNext <= '0;
        end
    end
`else
    assign oAddr    = '0;
    assign oAddrVld = 1'b0;
`endif
endmodule

// File: tb/tb_video_timing_gen.sv
// tb_video_timing_gen: randomized pixel-enable stimulus on three configurations, checked against an arithmetic raster model.
module tb_video_timing_gen;
    logic iClk = 1'b0;
    logic iRst = 1'b1;
    logic iPixEn = 1'b0;
    always #5 iClk = ~iClk;

    localparam int HVA [3] = '{640, 8, 8};
    localparam int HFP [3] = '{16, 2, 2};
    localparam int HSP [3] = '{96, 3, 3};
    localparam int HBP [3] = '{48, 2, 2};
    localparam int VVA [3] = '{480, 5, 5};
    localparam int VFP [3] = '{10, 1, 1};
    localparam int VSP [3] = '{2, 2, 2};
    localparam int VBP [3] = '{33, 1, 1};
    localparam int HPL [3] = '{0, 1, 0};
    localparam int VPL [3] = '{0, 1, 0};
    localparam int LD  [3] = '{0, 0, 2};

    logic deA, hsA, vsA, fsA, vlA;
    logic [9:0] xA, yA;
    logic [18:0] aA;
    logic deB, hsB, vsB, fsB, vlB;
    logic [3:0] xB, yB;
    logic [5:0] aB;
    logic deC, hsC, vsC, fsC, vlC;
    logic [3:0] xC, yC;
    logic [5:0] aC;

    video_timing_gen dutA (
        .iClk(iClk), .iRst(iRst), .iPixEn(iPixEn), .oDE(deA), .oHS(hsA), .oVS(vsA),
        .oX(xA), .oY(yA), .oFrameStart(fsA), .oAddr(aA), .oAddrVld(vlA)
    );
    video_timing_gen #(
        .H_VA(HVA[1]), .H_FP(HFP[1]), .H_SP(HSP[1]), .H_BP(HBP[1]),
        .V_VA(VVA[1]), .V_FP(VFP[1]), .V_SP(VSP[1]), .V_BP(VBP[1]),
        .HS_POL(HPL[1]), .VS_POL(VPL[1]), .LEAD(LD[1])
    ) dutB (
        .iClk(iClk), .iRst(iRst), .iPixEn(iPixEn), .oDE(deB), .oHS(hsB), .oVS(vsB),
        .oX(xB), .oY(yB), .oFrameStart(fsB), .oAddr(aB), .oAddrVld(vlB)
    );
    video_timing_gen #(
        .H_VA(HVA[2]), .H_FP(HFP[2]), .H_SP(HSP[2]), .H_BP(HBP[2]),
        .V_VA(VVA[2]), .V_FP(VFP[2]), .V_SP(VSP[2]), .V_BP(VBP[2]),
        .HS_POL(HPL[2]), .VS_POL(VPL[2]), .LEAD(LD[2])
    ) dutC (
        .iClk(iClk), .iRst(iRst), .iPixEn(iPixEn), .oDE(deC), .oHS(hsC), .oVS(vsC),
        .oX(xC), .oY(yC), .oFrameStart(fsC), .oAddr(aC), .oAddrVld(vlC)
    );

    int total = 0;
    int bad = 0;
    int n = 0;
    int ma [3];
    logic mv [3];

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s got=%0d want=%0d", tag, o, e);
        end
    endtask

    // Pixel index p counted from the frame start after reset -> raster position.
    function automatic void geom(input int i, input int p, output int x, output int y);
        int ht, vt, f;
        ht = HVA[i] + HFP[i] + HSP[i] + HBP[i];
        vt = VVA[i] + VFP[i] + VSP[i] + VBP[i];
        f = p % (ht * vt);
        x = f % ht;
        y = f / ht;
    endfunction

    task automatic checkInst(input int i, input string nm, input logic de, input logic hs,
                             input logic vs, input logic fs, input logic [31:0] x,
                             input logic [31:0] y, input logic [31:0] a, input logic vl);
        int p, ex, ey;
        logic ede, ehs, evs, efs, hIn, vIn;
        p = n - 1 - LD[i];
        ex = 0;
        ey = 0;
        hIn = 1'b0;
        vIn = 1'b0;
        ede = 1'b0;
        efs = 1'b0;
        if (p >= 0) begin
            geom(i, p, ex, ey);
            ede = ex < HVA[i] && ey < VVA[i];
            hIn = ex >= HVA[i] + HFP[i] && ex < HVA[i] + HFP[i] + HSP[i];
            vIn = ey >= VVA[i] + VFP[i] && ey < VVA[i] + VFP[i] + VSP[i];
            efs = ex == 0 && ey == 0;
        end
        ehs = hIn ? (HPL[i] != 0) : (HPL[i] == 0);
        evs = vIn ? (VPL[i] != 0) : (VPL[i] == 0);
        chk({nm, ".de"}, 32'(de), 32'(ede));
        chk({nm, ".hs"}, 32'(hs), 32'(ehs));
        chk({nm, ".vs"}, 32'(vs), 32'(evs));
        chk({nm, ".fs"}, 32'(fs), 32'(efs));
        chk({nm, ".x"}, x, ex);
        chk({nm, ".y"}, y, ey);
`ifdef VTG_ADDR_EN
        chk({nm, ".addr"}, a, ma[i]);
        chk({nm, ".vld"}, 32'(vl), 32'(mv[i]));
`else
        chk({nm, ".addr"}, a, 32'd0);
        chk({nm, ".vld"}, 32'(vl), 32'd0);
`endif
    endtask

    task automatic step(input logic r, input logic e);
        int ax, ay;
        iRst = r;
        iPixEn = e;
        @(posedge iClk);
        if (r) begin
            n = 0;
            for (int i = 0; i < 3; i++) begin
                ma[i] = 0;
                mv[i] = 1'b0;
            end
        end else if (e) begin
            n++;
            for (int i = 0; i < 3; i++) begin
                geom(i, n - 1, ax, ay);
                mv[i] = ax < HVA[i] && ay < VVA[i];
                if (mv[i]) ma[i] = ay * HVA[i] + ax;
            end
        end
        @(negedge iClk);
        checkInst(0, "A", deA, hsA, vsA, fsA, 32'(xA), 32'(yA), 32'(aA), vlA);
        checkInst(1, "B", deB, hsB, vsB, fsB, 32'(xB), 32'(yB), 32'(aB), vlB);
        checkInst(2, "C", deC, hsC, vsC, fsC, 32'(xC), 32'(yC), 32'(aC), vlC);
    endtask

    initial begin
        step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        repeat (2500) step(1'b0, 1'b1);
        repeat (200) begin
            step(1'b0, 1'b1);
            step(1'b0, 1'b0);
        end
        step(1'b1, 1'b1);
        repeat (2000) step(1'b0, $urandom_range(0, 3) != 0);
        repeat (3) step(1'b1, 1'b0);
        repeat (300) step(1'b0, 1'b1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
